serial_addsub: RTL

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_if.sv | 40 ++++
 rtl/serial_addsub.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// -----------------------------------------------------------------------------
// serial_addsub_if
// Request/response bundle for the bit-serial adder/subtractor.
// Build option: none here (saturation is selected inside serial_addsub by
// SERIAL_ADDSUB_SATURATE_EN).
//
// Signals (WIDTH = operand/result width):
//   start  : request to begin an operation (requester -> unit)
//   sub    : 0 = a+b, 1 = a-b, sampled with start (requester -> unit)
//   a, b   : two's-complement operands, sampled with start (requester -> unit)
//   busy   : operation in progress (unit -> requester)
//   done   : one-cycle pulse, result fields valid (unit -> requester)
//   result : sum/difference, held until the next operation completes
//   cout   : carry out of MSB (subtract: 1 = no borrow)
//   ovf    : signed overflow
// Modports: master = requester, slave = serial_addsub.
// -----------------------------------------------------------------------------
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, ovf
    );
endinterface : serial_addsub_if

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
// Bit-serial two's-complement adder/subtractor: one full adder evaluated per
// clock, LSB first. An accepted start latches the operands (b pre-inverted and
// carry seeded with 1 for subtraction); WIDTH RUN cycles later the result,
// carry-out and signed-overflow flags update together with a one-cycle done.
//
// Build option: define SERIAL_ADDSUB_SATURATE_EN to clamp the result to the
// most-positive / most-negative value on signed overflow (cout/ovf stay raw).
// Without it the result wraps modulo 2^WIDTH.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_addsub_if.slave (start/sub/a/b in; busy/done/result/cout/ovf out)
// Parameter: WIDTH, legal range 2..32.
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH-1:0] r_a;        // operand A, shifted right one bit per RUN cycle
    logic [WIDTH-1:0] r_b;        // operand B (inverted for subtract), shifted likewise
    logic             r_carry;    // carry into the bit being processed
    logic [CNT_W-1:0] r_cnt;      // index of the bit being processed
    logic [WIDTH-2:0] r_sum;      // sum bits collected so far, newest at the top
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sum;
    logic             w_carry;
    logic             w_last;
    logic [WIDTH-1:0] w_shift;
    logic             w_ovf;
    logic [WIDTH-1:0] w_final;

    // ---------------------------------------------------------------- FSM ---
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last = (r_cnt == CNT_LAST);

    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) w_state_nxt = RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = bus.start ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath ---
    assign w_sum   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

    // Full sum including the bit produced this cycle; on the last bit this
    // is the complete raw result with bit 0 in position 0.
    assign w_shift = {w_sum, r_sum};

    // On the last bit r_carry is the carry into the MSB.
    assign w_ovf = r_carry ^ w_carry;

`ifdef SERIAL_ADDSUB_SATURATE_EN
    // On the last bit r_a[0] holds the original sign of A, which gives the
    // overflow direction.
    assign w_final = !w_ovf ? w_shift :
                     r_a[0] ? {1'b1, {(WIDTH-1){1'b0}}} :
                              {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_final = w_shift;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b ^ {WIDTH{bus.sub}};
                        r_carry <= bus.sub;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry;
                    r_sum   <= w_shift[WIDTH-1:1];
                    if (w_last) begin
                        r_result <= w_final;
                        r_cout   <= w_carry;
                        r_ovf    <= w_ovf;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;

endmodule : serial_addsub
